// File: rtl/game_pkg.sv
// Shared constants and draw-sequencer state type for the screen drawers
// (game-over, title and clear-screen).
package game_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/over_draw_ctrl_xy_to_addr.sv
// Linear image address from screen coordinates: y*160 + x.
// 160 = 128 + 32, so the product is two shifts and an add.
module xy_to_addr
    import game_pkg::*;
(
    input  logic [8:0]        x,
    input  logic [6:0]        y,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext = {{(ADDR_W-9){1'b0}}, x};
    assign y_ext = {{(ADDR_W-7){1'b0}}, y};
    assign addr  = (y_ext << 7) + (y_ext << 5) + x_ext;

endmodule

// File: rtl/over_draw_ctrl.sv
// Game-over screen drawer: steps the scanner, reads the image ROM and
// issues plots aligned to the ROM's one-cycle read latency.
module over_draw_ctrl
    import game_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [8:0]          scan_x,
    input  logic [6:0]          scan_y,
    input  logic                scan_last,
    output logic                scan_resetn,
    output logic                scan_en,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [8:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    draw_state_t state_q, state_d;
    logic [8:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic        plot_q, plot_d;

    xy_to_addr u_addr (
        .x    (scan_x),
        .y    (scan_y),
        .addr (rom_addr)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_DRAW;
            ST_DRAW:  if (scan_last) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Coordinates are registered alongside the ROM read so colour lines up.
    always_comb begin
        vga_x_d = vga_x_q;
        vga_y_d = vga_y_q;
        plot_d  = 1'b0;
        if (state_q == ST_DRAW) begin
            vga_x_d = scan_x;
            vga_y_d = scan_y;
            plot_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            vga_x_q <= '0;
            vga_y_q <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vga_x_q <= vga_x_d;
            vga_y_q <= vga_y_d;
            plot_q  <= plot_d;
        end
    end

    // Scanner stays out of reset through FLUSH so it holds its last pixel.
    assign scan_resetn = (state_q == ST_DRAW) || (state_q == ST_FLUSH);
    assign scan_en     = (state_q == ST_DRAW);
    assign busy        = (state_q == ST_DRAW) || (state_q == ST_FLUSH);
    assign done        = (state_q == ST_DONE);
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = rom_q;
    assign plot        = plot_q;

endmodule

// File: tb/tb_over_draw_ctrl.sv
// Bench for over_draw_ctrl: scanner and ROM harness plus a pixel-index
// model of the expected plot stream.
module tb_over_draw_ctrl;
    import game_pkg::*;

    logic                clk = 1'b0;
    logic                resetn;
    logic                start;
    logic [8:0]          scan_x;
    logic [6:0]          scan_y;
    logic                scan_last;
    logic                scan_resetn;
    logic                scan_en;
    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_q;
    logic [8:0]          vga_x;
    logic [6:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                plot;
    logic                busy;
    logic                done;

    logic [8:0] sx;
    logic [6:0] sy;
    logic       ovr;
    logic [8:0] ovr_x;
    logic [6:0] ovr_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    over_draw_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .scan_x      (scan_x),
        .scan_y      (scan_y),
        .scan_last   (scan_last),
        .scan_resetn (scan_resetn),
        .scan_en     (scan_en),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    // Full-screen scanner and a ROM whose word is addr[2:0].
    always @(posedge clk) begin
        if (!scan_resetn) begin
            sx <= 9'd0;
            sy <= 7'd0;
        end else if (scan_en) begin
            if (sx == 9'(SCR_W - 1)) begin
                sx <= 9'd0;
                sy <= sy + 7'd1;
            end else begin
                sx <= sx + 9'd1;
            end
        end
        rom_q <= rom_addr[2:0];
    end

    assign scan_x    = ovr ? ovr_x : sx;
    assign scan_y    = ovr ? ovr_y : sy;
    assign scan_last = (scan_x == 9'(SCR_W - 1)) && (scan_y == 7'(SCR_H - 1));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int addr;
    } addr_vec_t;

    // Runs one draw from an IDLE negedge; returns at the IDLE negedge after done.
    task automatic draw(input bit extra_start, output int nplot, output int ndone);
        int k;
        int errs;
        int x159;
        int y159;
        int x160;
        int y160;
        int last_x;
        int last_y;
        int last_c;
        k = 0; errs = 0; ndone = 0;
        x159 = -1; y159 = -1; x160 = -1; y160 = -1;
        last_x = -1; last_y = -1; last_c = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat1_plot", int'(plot), 0);
        check("lat1_busy", int'(busy), 1);
        @(negedge clk);
        check("first_plot", int'(plot), 1);
        check("first_xy", int'(vga_x) * 1000 + int'(vga_y), 0);
        check("first_colour", int'(vga_colour), 0);
        while (plot && k < 20000) begin
            if (int'(vga_x) != k % SCR_W) errs++;
            if (int'(vga_y) != k / SCR_W) errs++;
            if (int'(vga_colour) != k % 8) errs++;
            if (done) ndone++;
            if (k == SCR_W - 1) begin x159 = vga_x; y159 = vga_y; end
            if (k == SCR_W) begin x160 = vga_x; y160 = vga_y; end
            last_x = vga_x; last_y = vga_y; last_c = vga_colour;
            start = (extra_start && k == 5000);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        nplot = k;
        check("plot_count", k, SCR_W * SCR_H);
        check("pixel_seq_errs", errs, 0);
        check("wrap_before", x159 * 1000 + y159, 159000);
        check("wrap_after", x160 * 1000 + y160, 1);
        check("last_xy", last_x * 1000 + last_y, 159119);
        check("last_colour", last_c, 7);
        check("done_after_last", int'(done), 1);
        if (done) ndone++;
        @(negedge clk);
        check("done_single", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_plot", int'(plot), 0);
    endtask

    initial begin
        addr_vec_t vecs[6];
        int np;
        int nd;
        int tot_p;
        int tot_d;
        int n;
        int bad;
        vecs[0] = '{0, 0, 0};
        vecs[1] = '{37, 42, 6757};
        vecs[2] = '{159, 0, 159};
        vecs[3] = '{0, 1, 160};
        vecs[4] = '{159, 119, 19199};
        vecs[5] = '{80, 60, 9680};

        resetn = 1'b0; start = 1'b0;
        ovr = 1'b0; ovr_x = '0; ovr_y = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("rst_plot", int'(plot), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_scan_resetn", int'(scan_resetn), 0);
        check("rst_scan_en", int'(scan_en), 0);
        check("rst_vga_xy", int'(vga_x) + int'(vga_y), 0);
        resetn = 1'b1;
        @(negedge clk);

        ovr = 1'b1;
        foreach (vecs[i]) begin
            ovr_x = 9'(vecs[i].x);
            ovr_y = 7'(vecs[i].y);
            #1;
            check("addr_vec", int'(rom_addr), vecs[i].addr);
        end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            int rx;
            int ry;
            rx = $urandom_range(SCR_W - 1, 0);
            ry = $urandom_range(SCR_H - 1, 0);
            ovr_x = 9'(rx);
            ovr_y = 7'(ry);
            #1;
            if (int'(rom_addr) != ry * SCR_W + rx) bad++;
        end
        check("addr_random_errs", bad, 0);
        ovr = 1'b0;
        @(negedge clk);
        check("idle_stays", int'(busy) + int'(plot), 0);

        draw(1'b0, np, nd);
        check("draw1_dones", nd, 1);

        repeat ($urandom_range(6, 1)) @(negedge clk);
        draw(1'b1, np, nd);
        check("restart_ignored_dones", nd, 1);

        repeat ($urandom_range(6, 1)) @(negedge clk);
        tot_p = 0; tot_d = 0;
        draw(1'b0, np, nd);
        tot_p += np; tot_d += nd;
        draw(1'b0, np, nd);
        tot_p += np; tot_d += nd;
        check("b2b_plots", tot_p, 2 * SCR_W * SCR_H);
        check("b2b_dones", tot_d, 2);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(plot && vga_x == 9'd80 && vga_y == 7'd60) && n < 20000) begin
            n++;
            @(negedge clk);
        end
        check("reach_80_60", int'(n < 20000), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_plot", int'(plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (plot || done || busy) bad++;
        end
        check("midrst_quiet", bad, 0);
        draw(1'b0, np, nd);
        check("after_rst_dones", nd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/over_draw_ctrl.md
Name: over_draw_ctrl

Overview:
Sequencer and pixel pipeline for the game-over screen. On a start pulse it releases and enables the full-screen coordinate scanner and converts each scanned (x,y) into a game-over image ROM address. It then emits (x, y, colour, plot) writes to the VGA adapter, aligned with the 1-cycle ROM read latency. It stops on the scanner's last-pixel flag and pulses done to the game FSM.

Parameters:
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels
COLOUR_W, 3, VGA adapter colour width
ADDR_W, 15, image ROM address width (SCR_W*SCR_H = 19200 entries)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  single-cycle request to draw the game-over screen
scan_x  in  9  scanner x coordinate
scan_y  in  7  scanner y coordinate
scan_last  in  1  scanner flag, high when the scanner is at (159,119)
scan_resetn  out  1  active-low reset to the scanner
scan_en  out  1  scanner step enable
rom_addr  out  ADDR_W  image ROM address (ROM has synchronous read, latency 1)
rom_q  in  COLOUR_W  ROM data, valid 1 cycle after rom_addr
vga_x  out  9  plot x
vga_y  out  7  plot y
vga_colour  out  COLOUR_W  plot colour
plot  out  1  VGA write strobe
busy  out  1  high from the start-accept cycle through the FLUSH state
done  out  1  1-cycle pulse at draw completion

Behaviour:
- Reset and clock: resetn is synchronous, active-low; clock is clk. Reset has priority over all state.
- Reset values: state=IDLE; vga_x=0, vga_y=0, plot=0, busy=0, done=0, scan_en=0, scan_resetn=0.
- FSM states: IDLE, DRAW, FLUSH, DONE.
  - IDLE: scan_resetn=0, which holds the scanner at (0,0). A start pulse moves to DRAW.
  - DRAW: scan_resetn=1, scan_en=1, busy=1. Each cycle the scanner presents one new pixel. When scan_last=1 in DRAW, go to FLUSH.
  - FLUSH: scan_en=0, busy=1. Exists only so the final pipelined pixel is emitted. Unconditionally goes to DONE.
  - DONE: done=1 for exactly this cycle, scan_resetn=0. Next state is IDLE.
- start handling: start is ignored in DRAW, FLUSH and DONE. It is not queued.
- Address arithmetic: rom_addr = scan_y*160 + scan_x, computed combinationally as (y<<7)+(y<<5)+x at 15 bits. The range is 0..19199, with no overflow. rom_addr is don't-care outside DRAW.
- Pipeline, 1 stage. On every DRAW cycle:
  - vga_x <= scan_x;
  - vga_y <= scan_y;
  - plot <= 1.
  - vga_colour = rom_q combinationally, so it is valid in the same cycle as the registered plot.
  - In all other states plot <= 0. vga_x/vga_y hold their last value.
- Timing: the first plot (0,0) occurs 2 cycles after the start cycle. The last plot (159,119) occurs in the FLUSH cycle. done follows in the next cycle.
- Plot count: exactly 19200 plot pulses per draw, with no gaps. Row wrap (159→0, y+1) produces no stall.
- Mid-draw reset: resetn low in any state returns all outputs to reset values on the next edge. No partial done is produced.
- Back-to-back draws: a start arriving in the cycle after done (IDLE) begins a fresh draw from (0,0).

Decomposition:
- Shared package game_pkg holds:
  - constants SCR_W, SCR_H, COLOUR_W;
  - the FSM state enum draw_state_t (also used by the title/clear-screen drawers).
- The address computation is one natural sub-module: xy_to_addr (combinational y*160+x). Everything else stays flat.

Test Plan:
- Reset: assert resetn=0 for 2 cycles with start toggling -> plot=0, done=0, busy=0, scan_resetn=0, state IDLE.
- Full draw, using the real scanner and a ROM holding addr[2:0]: pulse start -> the first plot is at (0,0) with colour 0, 2 cycles later. Exactly 19200 plots follow. Pixel (159,0) is followed by (0,1). The last plot is (159,119) with colour 19199[2:0]=7. done is high exactly 1 cycle after that plot.
- Start during draw: pulse start at pixel count 5000 -> no restart. The plot count is still 19200 and there is a single done pulse.
- Mid-draw reset: resetn=0 at pixel (80,60) -> next cycle plot=0 and busy=0. After release there are no plots until a new start, which restarts at (0,0).
- Back-to-back: start in the IDLE cycle right after done -> the second draw begins at (0,0), giving 38400 total plots and 2 done pulses.
- Address spot-check: the scanner presents (37,42) -> rom_addr=6757.
